// File: rtl/slice_log_capture.sv
// slice_log_capture: decimated capture of a slice's signed log value plus its
// address tag into a small show-ahead FIFO. Captures that find the FIFO full
// (with no pop on the same edge) are dropped and counted.
module slice_log_capture #(
    parameter int DATA_WIDTH = 24,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                            clock_200,
    input  logic                            reset,
    input  logic                            logging_trigger,
    input  logic [TAG_WIDTH-1:0]            logging_address,
    input  logic signed [DATA_WIDTH-1:0]    log_value,
    input  logic [7:0]                      decimation,
    input  logic                            clear_overflow,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data,
    output logic [DEPTH_LOG2:0]             fifo_count,
    output logic                            overflow,
    output logic [15:0]                     dropped_count
);

    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // Storage is not reset; contents only matter behind a valid count.
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [7:0]            dec_cnt_q, dec_cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           dropped_q, dropped_d;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Next-state: decimation, FIFO bookkeeping and drop accounting.
    always_comb begin
        dec_cnt_d  = dec_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;

        capture = logging_trigger && (dec_cnt_q == 8'd0);
        full    = (count_q == FULL_COUNT);
        pop     = (count_q != '0) && out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;

        // ">=" also folds a counter stranded above a lowered decimation back to 0.
        if (logging_trigger) begin
            dec_cnt_d = (dec_cnt_q >= decimation) ? 8'd0 : dec_cnt_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Clear first, then a same-edge drop re-arms the flag and counts 1.
        if (clear_overflow) begin
            overflow_d = 1'b0;
            dropped_d  = 16'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_d != 16'hFFFF) begin
                dropped_d = dropped_d + 16'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_200) begin
        if (reset) begin
            dec_cnt_q  <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 16'd0;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Entry write; the value is stored as raw two's complement bits.
    always_ff @(posedge clock_200) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= {logging_address, log_value};
        end
    end

    // Show-ahead head: the entry is visible as soon as the count is non-zero.
    assign out_data      = mem[rd_ptr_q];
    assign out_valid     = (count_q != '0);
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_slice_log_capture.sv
// Testbench for slice_log_capture: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_slice_log_capture;

    logic        clock_200 = 1'b0;
    logic        reset = 1'b1;
    logic        logging_trigger = 1'b0;
    logic [3:0]  logging_address = '0;
    logic signed [23:0] log_value = '0;
    logic [7:0]  decimation = '0;
    logic        clear_overflow = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [27:0] out_data;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] dropped_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [27:0] model_q[$];
    int          m_cnt = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;

    always #5 clock_200 = ~clock_200;

    slice_log_capture #(.DATA_WIDTH(24), .TAG_WIDTH(4), .DEPTH_LOG2(4)) dut (
        .clock_200(clock_200),
        .reset(reset),
        .logging_trigger(logging_trigger),
        .logging_address(logging_address),
        .log_value(log_value),
        .decimation(decimation),
        .clear_overflow(clear_overflow),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .dropped_count(dropped_count)
    );

    // One clock cycle: apply inputs, advance the model, then sample 1 ns after the edge.
    task automatic drive(input bit trig, input logic [3:0] tag, input logic [23:0] val,
                         input bit rdy, input bit clr, input bit rst);
        bit cap;
        logging_trigger = trig;
        logging_address = tag;
        log_value       = val;
        out_ready       = rdy;
        clear_overflow  = clr;
        reset           = rst;
        if (rst) begin
            model_q.delete();
            m_cnt  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            cap = trig && (m_cnt == 0);
            if (trig) begin
                if (m_cnt == int'(decimation) || m_cnt > int'(decimation)) m_cnt = 0;
                else m_cnt = m_cnt + 1;
            end
            if (clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (rdy && model_q.size() > 0) void'(model_q.pop_front());
            if (cap) begin
                if (model_q.size() < 16) model_q.push_back({tag, val});
                else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop = m_drop + 1;
                end
            end
        end
        @(posedge clock_200);
        #1;
        logging_trigger = 1'b0;
        out_ready       = 1'b0;
        clear_overflow  = 1'b0;
        reset           = 1'b0;
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count); end
        $display("test_reset done");
    endtask

    task automatic test_single;
        decimation = 8'd0;
        drive(1, 4'd4, 24'd8000000, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== {4'd4, 24'd8000000}) begin errors++; $display("FAIL single_data: got %h expected %h", out_data, {4'd4, 24'd8000000}); end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", out_valid); end
        // out_ready on an empty FIFO must not underflow the count
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", fifo_count); end
        $display("test_single: tag=4 value=8000000 captured and popped");
    endtask

    task automatic test_decimation;
        int exp_v[3] = '{1, 4, 7};
        decimation = 8'd2;
        for (int i = 1; i <= 9; i++) drive(1, 4'(i), 24'(i), 0, 0, 0);
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL dec_count: got %0d expected 3", fifo_count); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_data !== {4'(exp_v[k]), 24'(exp_v[k])}) begin
                errors++; $display("FAIL dec_entry%0d: got %h expected %h", k, out_data, {4'(exp_v[k]), 24'(exp_v[k])});
            end
            $display("pop tag=%0d value=%0d", out_data[27:24], out_data[23:0]);
            drive(0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_overflow;
        drive(0, 0, 0, 0, 0, 1);
        decimation = 8'd0;
        for (int i = 0; i < 18; i++) drive(1, 4'(i), 24'(100 + i), 0, 0, 0);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (dropped_count !== 16'd2) begin errors++; $display("FAIL ovf_dropped: got %0d expected 2", dropped_count); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data !== {4'(i), 24'(100 + i)}) begin
                errors++; $display("FAIL ovf_entry%0d: got %h expected %h", i, out_data, {4'(i), 24'(100 + i)});
            end
            drive(0, 0, 0, 1, 0, 0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
        $display("test_overflow: 16 entries read back");
    endtask

    task automatic test_full_push_pop;
        logic [15:0] drop_before;
        drive(0, 0, 0, 0, 1, 0);
        decimation = 8'd0;
        for (int i = 0; i < 16; i++) drive(1, 4'(i), 24'(200 + i), 0, 0, 0);
        drop_before = dropped_count;
        drive(1, 4'd9, 24'd999, 1, 0, 0);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL pp_count: got %0d expected 16", fifo_count); end
        checks++; if (dropped_count !== drop_before) begin errors++; $display("FAIL pp_dropped: got %0d expected %0d", dropped_count, drop_before); end
        checks++; if (out_data !== {4'd1, 24'd201}) begin errors++; $display("FAIL pp_head: got %h expected %h", out_data, {4'd1, 24'd201}); end
        for (int i = 0; i < 15; i++) drive(0, 0, 0, 1, 0, 0);
        checks++; if (out_data !== {4'd9, 24'd999}) begin errors++; $display("FAIL pp_tail: got %h expected %h", out_data, {4'd9, 24'd999}); end
        drive(0, 0, 0, 1, 0, 0);
        $display("test_full_push_pop: tail tag=9 value=999");
    endtask

    task automatic test_reset_mid;
        decimation = 8'd3;
        for (int i = 0; i < 17; i++) drive(1, 4'd2, 24'(i), 0, 0, 0);
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL mid_precount: got %0d expected 5", fifo_count); end
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
        drive(1, 4'd7, -24'sd5, 0, 0, 0);
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL mid_capture_count: got %0d expected 1", fifo_count); end
        checks++; if (out_data !== {4'd7, 24'hFFFFFB}) begin errors++; $display("FAIL mid_capture_data: got %h expected %h", out_data, {4'd7, 24'hFFFFFB}); end
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_clear_drop;
        decimation = 8'd0;
        for (int i = 0; i < 20; i++) drive(1, 4'd3, 24'(i), 0, 0, 0);
        checks++; if (dropped_count !== 16'd4) begin errors++; $display("FAIL cd_pre: got %0d expected 4", dropped_count); end
        drive(1, 4'd3, 24'd50, 0, 1, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL cd_flag: got %b expected 1", overflow); end
        checks++; if (dropped_count !== 16'd1) begin errors++; $display("FAIL cd_dropped: got %0d expected 1", dropped_count); end
        drive(0, 0, 0, 0, 1, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL cd_clear_flag: got %b expected 0", overflow); end
        checks++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL cd_clear_dropped: got %0d expected 0", dropped_count); end
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 5) decimation = 8'($urandom_range(0, 5));
            drive($urandom_range(0, 99) < 60, 4'($urandom), 24'($urandom),
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 199) == 0);
            checks++; if (out_valid !== (model_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, model_q.size() != 0); end
            checks++; if (fifo_count !== 5'(model_q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, fifo_count, model_q.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b expected %b", n, overflow, m_ovf); end
            checks++; if (dropped_count !== 16'(m_drop)) begin errors++; $display("FAIL rnd_dropped@%0d: got %0d expected %0d", n, dropped_count, m_drop); end
            if (model_q.size() != 0) begin
                checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", n, out_data, model_q[0]); end
            end
        end
        $display("test_random: 3000 cycles");
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_decimation();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_clear_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slice_log_capture.md
SLICE_LOG_CAPTURE -- requirements
Module: slice_log_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning width of the signed log value from the slice.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, meaning width of the logging address tag.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of FIFO depth (16 entries).
REQ-004 SHALL have port clock_200, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port logging_trigger, input, 1 bit: capture request from the VLIW sequencer.
REQ-007 SHALL have port logging_address, input, TAG_WIDTH: tag stored with each captured value.
REQ-008 SHALL have port log_value, input, DATA_WIDTH signed: the slice's log_value_reconstructed.
REQ-009 SHALL have port decimation, input, 8 bits: store one trigger in every decimation+1.
REQ-010 SHALL have port clear_overflow, input, 1 bit: clears overflow and dropped_count.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-012 SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-013 SHALL have port out_data, output, TAG_WIDTH+DATA_WIDTH: {tag, value} of the head entry.
REQ-014 SHALL have port fifo_count, output, DEPTH_LOG2+1: number of stored entries.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set on any dropped capture.
REQ-016 SHALL have port dropped_count, output, 16 bits: saturating count of dropped captures.

Function
REQ-017 SHALL sample logging_trigger, logging_address and log_value together on the same rising edge.
REQ-018 SHALL keep a decimation counter that starts at 0 and advances only on edges where logging_trigger=1.
REQ-019 SHALL treat a trigger as a capture when the counter equals 0.
REQ-020 SHALL increment the counter after each trigger and wrap it to 0 once it equals decimation; decimation=0 SHALL make every trigger a capture.
REQ-021 SHALL wrap the counter to 0 on the next trigger if decimation is lowered below the current counter value.
REQ-022 SHALL write a capture into the FIFO on the sampling edge, so out_valid rises in the following cycle when the FIFO was empty (latency 1).
REQ-023 SHALL present the head entry show-ahead: out_data SHALL be valid whenever out_valid=1 and SHALL hold stable until the entry is popped.
REQ-024 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-025 SHALL accept both a pop and a push on the same edge, including when full, leaving fifo_count unchanged.
REQ-026 SHALL drop a capture that arrives when full with no pop; the drop SHALL set overflow and increment dropped_count, which saturates at 65535.
REQ-027 SHALL wrap the read and write pointers modulo 2^DEPTH_LOG2; fifo_count SHALL range 0..2^DEPTH_LOG2.
REQ-028 SHALL give a drop on the same edge as clear_overflow priority: overflow=1 and dropped_count=1 after that edge.
REQ-029 SHALL store log_value unmodified as two's complement; no saturation or rescaling.

Reset
REQ-030 SHALL, while reset=1 at an edge, set out_valid=0, fifo_count=0, overflow=0, dropped_count=0, both pointers and the decimation counter to 0, and ignore triggers and pops.
REQ-031 SHALL, on reset asserted mid-operation, discard all stored entries; the first trigger after reset SHALL be a capture.
REQ-032 SHALL not reset the memory array contents; out_data SHALL be don't-care while out_valid=0.

Verification
REQ-033 SHALL be covered by: decimation=0, single trigger (tag 4, value 24'sd8000000) -> out_valid high next cycle, out_data={4'd4,24'sd8000000}, fifo_count=1.
REQ-034 SHALL be covered by: decimation=2, 9 consecutive triggers, out_ready=0 -> captures 1, 4, 7 stored, fifo_count=3.
REQ-035 SHALL be covered by: out_ready=0, 18 triggers with decimation=0 -> fifo_count=16, overflow=1, dropped_count=2; first 16 values read back in order.
REQ-036 SHALL be covered by: full FIFO, trigger and out_ready=1 on the same edge -> fifo_count stays 16, dropped_count unchanged, new entry at tail.
REQ-037 SHALL be covered by: reset pulsed for one cycle with 5 entries stored -> out_valid=0, fifo_count=0 next cycle; the next trigger is captured.
REQ-038 SHALL be covered by: clear_overflow and a dropping capture on the same edge -> overflow=1, dropped_count=1.
